sorter_param: RTL and testbench
===============================

// Module: sorter_param
// PURPOSE
// Parametrised package sorter, next generation of the fixed six-group sorter.
// Classifies the weight on the scale into NUM_GROUPS bins using packed threshold limits.
// Counts each package exactly once, after the weight has been stable for STABLE_CYCLES samples.
// Provides per-group counters with saturate or wrap overflow, sticky overflow flags, a total
// count, a sort strobe and a synchronous clear; feeds the display/readout logic of the lab top.
// PARAMETERS
// WEIGHT_W      12                     weight bus width
// NUM_GROUPS    6                      number of bins, legal range 2..8
// LIMITS        {12'd2000,12'd1500,12'd750,12'd500,12'd250}
//                                      packed upper limits, (NUM_GROUPS-1)*WEIGHT_W bits;
//                                      L1 in LSBs, must be strictly increasing
// COUNT_W       8                      width of each group counter
// TOTAL_W       16                     width of total counter; always wraps
// STABLE_CYCLES 2                      consecutive equal nonzero samples needed to count (>=1)
// SATURATE      1                      1: group counters hold at max; 0: wrap to 0
// PORTS
// clock          in   1                      clock; all registers update on falling edge
// reset_n        in   1                      asynchronous, active-low reset
// weight         in   WEIGHT_W               scale reading; 0 = no package present
// clear          in   1                      sync clear of counters and flags
// counts         out  NUM_GROUPS*COUNT_W     group counters, group1 in LSBs
// overflow       out  NUM_GROUPS             sticky per-group overflow flags
// total          out  TOTAL_W                packages counted since reset/clear
// current_group  out  4                      combinational bin of weight; 0 when weight==0
// sorted         out  1                      one-cycle strobe on each counted package
// BEHAVIOUR
// - Classification (combinational):
//     weight==0                 -> 0
//     1<=w<=L1                  -> 1
//     L(k-1)<w<=Lk              -> k
//     w>L(NUM_GROUPS-1)         -> NUM_GROUPS
// - Reset (reset_n low, asynchronous): counts, overflow, total, sorted = 0; FSM=EMPTY.
//   A package on the scale at reset release is treated as new and is counted.
// - FSM, evaluated at each falling edge:
//   EMPTY:   weight==0 -> stay.
//            weight!=0 -> capture weight; stab=1; go SETTLE.
//            If STABLE_CYCLES==1, count now and go COUNTED instead.
//   SETTLE:  weight==0 -> EMPTY, no count.
//            weight!=captured -> recapture; stab=1.
//            weight==captured -> stab++; when stab reaches STABLE_CYCLES, count and go COUNTED.
//   COUNTED: stay while weight!=0, including weight changes (no recount).
//            weight==0 -> EMPTY.
// - Count event: increment counts[bin of captured weight] and total. sorted=1 for the
//   following clock period only.
// - Overflow: an increment at all-ones sets overflow[g], sticky until clear or reset.
//   SATURATE=1: counter holds at all-ones. SATURATE=0: counter wraps to 0.
//   total wraps silently.
// - clear=1 at an edge zeroes counts, overflow and total. FSM state is unaffected.
//   If clear coincides with a count event, clear wins: the increment is dropped,
//   but sorted still pulses and the FSM advances.
// - No x/z handling: weight must be driven; the bench drives 0 for an empty scale.
// TESTING
// 1. reset_n=0 mid-run -> all outputs 0 immediately (asynchronous);
//    weight=300 held after release -> counts[g2]=1 after 2 edges.
// 2. Defaults: weights 250, 251, 500, 2000, 2001, each held 3 cycles with 0 between ->
//    g1=1, g2=2, g5=1, g6=1, total=5, 5 sorted pulses.
// 3. weight 100 for 1 cycle, then 0 (STABLE_CYCLES=2) -> no count.
//    Then 100 -> 120 -> 120 -> g1 increments once, on the second 120 sample.
// 4. Package held 10 cycles, weight changing 600 -> 900 while COUNTED ->
//    g3=1 only, single sorted pulse.
// 5. SATURATE=1: 256 g1 packages -> g1=255, overflow[0]=1.
//    SATURATE=0: g1=0, overflow[0]=1.
// 6. clear asserted on the count edge -> counts and total stay 0, sorted pulses;
//    the next package counts normally.

Source files
------------

// File: rtl/sorter_param.sv
// ---------------------------------------------------------------------------
// sorter_param
//
// Parametrised package sorter. Bins the weight on the scale into NUM_GROUPS
// groups using packed upper limits. A package is counted once, after its
// weight has read the same nonzero value for STABLE_CYCLES consecutive
// samples. Keeps per-group counters (saturating or wrapping), sticky
// per-group overflow flags, a wrapping total and a one-cycle sort strobe.
// All registers update on the falling edge of clock.
//
// Ports:
//   clock          in   1                    clock, falling-edge active
//   reset_n        in   1                    asynchronous active-low reset
//   weight         in   WEIGHT_W             scale reading, 0 = empty scale
//   clear          in   1                    synchronous clear of counters/flags
//   counts         out  NUM_GROUPS*COUNT_W   group counters, group 1 in LSBs
//   overflow       out  NUM_GROUPS           sticky per-group overflow flags
//   total          out  TOTAL_W              packages counted since reset/clear
//   current_group  out  4                    combinational bin of weight
//   sorted         out  1                    one-cycle strobe per counted package
// ---------------------------------------------------------------------------
module sorter_param #(
  parameter int WEIGHT_W      = 12,
  parameter int NUM_GROUPS    = 6,
  parameter logic [(NUM_GROUPS-1)*WEIGHT_W-1:0] LIMITS =
    {12'd2000, 12'd1500, 12'd750, 12'd500, 12'd250},
  parameter int COUNT_W       = 8,
  parameter int TOTAL_W       = 16,
  parameter int STABLE_CYCLES = 2,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [WEIGHT_W-1:0]           weight,
  input  logic                          clear,
  output logic [NUM_GROUPS*COUNT_W-1:0] counts,
  output logic [NUM_GROUPS-1:0]         overflow,
  output logic [TOTAL_W-1:0]            total,
  output logic [3:0]                    current_group,
  output logic                          sorted
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1) + 1;

  typedef enum logic [1:0] {EMPTY, SETTLE, COUNTED} state_t;

  state_t                state_q, state_d;
  logic [WEIGHT_W-1:0]   capt_q, capt_d;
  logic [STAB_W-1:0]     stab_q, stab_d;
  logic                  count_event;
  logic [COUNT_W-1:0]    cnt_q [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] ovf_q;
  logic [TOTAL_W-1:0]    total_q;
  logic                  sorted_q;

  // Limits are strictly increasing, so scanning from the top limit down
  // leaves the lowest limit the weight still fits under.
  function automatic logic [3:0] classify(input logic [WEIGHT_W-1:0] w);
    logic [3:0] bin;
    bin = 4'(NUM_GROUPS);
    for (int k = NUM_GROUPS - 2; k >= 0; k--) begin
      if (w <= LIMITS[k*WEIGHT_W +: WEIGHT_W]) bin = 4'(k + 1);
    end
    if (w == '0) bin = '0;
    return bin;
  endfunction

  assign current_group = classify(weight);

  // State, captured weight and stability counter.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      capt_q  <= '0;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      capt_q  <= capt_d;
      stab_q  <= stab_d;
    end
  end

  // Next-state logic. A package is counted when the stable-sample count
  // reaches STABLE_CYCLES; once counted, weight changes are ignored until
  // the scale reads empty again.
  always_comb begin
    state_d     = state_q;
    capt_d      = capt_q;
    stab_d      = stab_q;
    count_event = 1'b0;
    case (state_q)
      EMPTY: begin
        if (weight != '0) begin
          capt_d = weight;
          stab_d = STAB_W'(1);
          if (STABLE_CYCLES == 1) begin
            count_event = 1'b1;
            state_d     = COUNTED;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (weight == '0) begin
          state_d = EMPTY;
        end else if (weight != capt_q) begin
          capt_d = weight;
          stab_d = STAB_W'(1);
        end else begin
          stab_d = stab_q + STAB_W'(1);
          if (stab_d == STAB_W'(STABLE_CYCLES)) begin
            count_event = 1'b1;
            state_d     = COUNTED;
          end
        end
      end
      COUNTED: begin
        if (weight == '0) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Counters, flags and strobe. A count event only happens when the current
  // weight equals the captured one, so the live bin is the captured bin.
  // Clear beats a simultaneous count, but the strobe still fires.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) cnt_q[g] <= '0;
      ovf_q    <= '0;
      total_q  <= '0;
      sorted_q <= 1'b0;
    end else begin
      sorted_q <= count_event;
      if (clear) begin
        for (int g = 0; g < NUM_GROUPS; g++) cnt_q[g] <= '0;
        ovf_q   <= '0;
        total_q <= '0;
      end else if (count_event) begin
        total_q <= total_q + TOTAL_W'(1);
        for (int g = 0; g < NUM_GROUPS; g++) begin
          if (current_group == 4'(g + 1)) begin
            if (cnt_q[g] == '1) begin
              ovf_q[g] <= 1'b1;
              cnt_q[g] <= SATURATE ? cnt_q[g] : '0;
            end else begin
              cnt_q[g] <= cnt_q[g] + COUNT_W'(1);
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_pack
    assign counts[g*COUNT_W +: COUNT_W] = cnt_q[g];
  end

  assign overflow = ovf_q;
  assign total    = total_q;
  assign sorted   = sorted_q;

endmodule

// File: tb/tb_sorter_param.sv
// ---------------------------------------------------------------------------
// tb_sorter_param
//
// Directed bench for sorter_param. Two instances share the stimulus: one with
// default (saturating) counters and one with wrapping counters. Inputs change
// on the rising edge, the design acts on the falling edge, and outputs are
// read on the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_sorter_param;

  logic        clock;
  logic        reset_n;
  logic [11:0] weight;
  logic        clear;
  logic [47:0] counts, countsWrap;
  logic [5:0]  overflow, overflowWrap;
  logic [15:0] total, totalWrap;
  logic [3:0]  currentGroup, currentGroupWrap;
  logic        sorted, sortedWrap;

  int vectors;
  int miscompares;
  int sortedCount;
  int snap;

  sorter_param dut (
    .clock(clock), .reset_n(reset_n), .weight(weight), .clear(clear),
    .counts(counts), .overflow(overflow), .total(total),
    .current_group(currentGroup), .sorted(sorted)
  );

  sorter_param #(.SATURATE(1'b0)) dutWrap (
    .clock(clock), .reset_n(reset_n), .weight(weight), .clear(clear),
    .counts(countsWrap), .overflow(overflowWrap), .total(totalWrap),
    .current_group(currentGroupWrap), .sorted(sortedWrap)
  );

  // 10 ns clock; falling edges at 10, 20, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tally strobe pulses well clear of both edges.
  always @(posedge clock) begin
    #2;
    if (sorted) sortedCount++;
  end

  function automatic int grp(input int g);
    return int'(counts[(g-1)*8 +: 8]);
  endfunction

  function automatic int grpWrap(input int g);
    return int'(countsWrap[(g-1)*8 +: 8]);
  endfunction

  // Hold weight for n falling edges; returns on a rising edge.
  task automatic applyStimulus(input logic [11:0] w, input int n);
    weight = w;
    repeat (n) @(negedge clock);
    @(posedge clock);
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    applyStimulus(12'd0, 1);
    clear = 1'b0;
  endtask

  logic [11:0] bndW [7] = '{12'd0, 12'd1, 12'd250, 12'd251, 12'd2000, 12'd2001, 12'd4095};
  int          bndG [7] = '{0, 1, 1, 2, 5, 6, 6};

  initial begin
    vectors     = 0;
    miscompares = 0;
    sortedCount = 0;
    reset_n     = 1'b0;
    weight      = '0;
    clear       = 1'b0;
    @(posedge clock);
    @(posedge clock);
    reset_n = 1'b1;

    // Package on the scale right after reset, counted on the second edge.
    applyStimulus(12'd300, 2);
    checkOutput("post-reset g2", grp(2), 1);
    checkOutput("post-reset total", int'(total), 1);
    applyStimulus(12'd0, 1);

    // Asynchronous reset mid-run, asserted while sorted is high.
    applyStimulus(12'd400, 2);
    checkOutput("pre-reset sorted", int'(sorted), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async counts", (counts == '0) ? 1 : 0, 1);
    checkOutput("async total", int'(total), 0);
    checkOutput("async sorted", int'(sorted), 0);
    checkOutput("async overflow", int'(overflow), 0);
    weight = 12'd300;
    @(posedge clock);
    reset_n = 1'b1;
    applyStimulus(12'd300, 1);
    checkOutput("release 1 edge g2", grp(2), 0);
    applyStimulus(12'd300, 1);
    checkOutput("release 2 edges g2", grp(2), 1);
    applyStimulus(12'd0, 1);

    // Default limits, boundary weights.
    pulseClear();
    snap = sortedCount;
    applyStimulus(12'd250, 3);  applyStimulus(12'd0, 1);
    applyStimulus(12'd251, 3);  applyStimulus(12'd0, 1);
    applyStimulus(12'd500, 3);  applyStimulus(12'd0, 1);
    applyStimulus(12'd2000, 3); applyStimulus(12'd0, 1);
    applyStimulus(12'd2001, 3); applyStimulus(12'd0, 1);
    checkOutput("bins g1", grp(1), 1);
    checkOutput("bins g2", grp(2), 2);
    checkOutput("bins g3", grp(3), 0);
    checkOutput("bins g4", grp(4), 0);
    checkOutput("bins g5", grp(5), 1);
    checkOutput("bins g6", grp(6), 1);
    checkOutput("bins total", int'(total), 5);
    checkOutput("bins pulses", sortedCount - snap, 5);

    // Unstable weights.
    pulseClear();
    applyStimulus(12'd100, 1);
    applyStimulus(12'd0, 1);
    checkOutput("blip g1", grp(1), 0);
    checkOutput("blip total", int'(total), 0);
    applyStimulus(12'd100, 1);
    applyStimulus(12'd120, 1);
    checkOutput("settle first 120", grp(1), 0);
    applyStimulus(12'd120, 1);
    checkOutput("settle second 120", grp(1), 1);
    applyStimulus(12'd0, 1);

    // Weight change while counted is not recounted.
    pulseClear();
    snap = sortedCount;
    applyStimulus(12'd600, 4);
    applyStimulus(12'd900, 6);
    applyStimulus(12'd0, 1);
    checkOutput("held g3", grp(3), 1);
    checkOutput("held g4", grp(4), 0);
    checkOutput("held total", int'(total), 1);
    checkOutput("held pulses", sortedCount - snap, 1);

    // Combinational classification at the limits, within one half period.
    for (int i = 0; i < 7; i++) begin
      weight = bndW[i];
      #0.5;
      checkOutput($sformatf("group w=%0d", bndW[i]), int'(currentGroup), bndG[i]);
    end
    weight = '0;
    @(posedge clock);

    // Counter overflow, saturating and wrapping.
    pulseClear();
    for (int i = 0; i < 255; i++) begin
      applyStimulus(12'd100, 2);
      applyStimulus(12'd0, 1);
    end
    checkOutput("255 sat g1", grp(1), 255);
    checkOutput("255 sat ovf", int'(overflow[0]), 0);
    checkOutput("255 wrap g1", grpWrap(1), 255);
    applyStimulus(12'd100, 2);
    applyStimulus(12'd0, 1);
    checkOutput("256 sat g1", grp(1), 255);
    checkOutput("256 sat ovf", int'(overflow[0]), 1);
    checkOutput("256 wrap g1", grpWrap(1), 0);
    checkOutput("256 wrap ovf", int'(overflowWrap[0]), 1);
    checkOutput("256 other ovf", int'(overflow[5:1]), 0);
    checkOutput("256 total", int'(total), 256);
    checkOutput("256 wrap total", int'(totalWrap), 256);

    // Clear on the count edge wins over the increment.
    pulseClear();
    checkOutput("clear ovf", int'(overflow), 0);
    snap = sortedCount;
    applyStimulus(12'd300, 1);
    clear = 1'b1;
    applyStimulus(12'd300, 1);
    clear = 1'b0;
    checkOutput("clear-win g2", grp(2), 0);
    checkOutput("clear-win total", int'(total), 0);
    applyStimulus(12'd0, 1);
    checkOutput("clear-win pulse", sortedCount - snap, 1);
    applyStimulus(12'd300, 2);
    applyStimulus(12'd0, 1);
    checkOutput("after clear g2", grp(2), 1);
    checkOutput("after clear total", int'(total), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
